// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter that applies one JK command per clock
// to a shared bank of WIDTH JK state bits.
//
// Optional feature macro: JK_TOGGLE_CNT_EN
//   When defined, a 16-bit saturating counter (tgl_cnt) counts applied
//   in-range J=1/K=1 (toggle) commands. When undefined, the port and
//   counter do not exist.
//
// Handshake: a requester raises req[i] with a stable payload (j_in[i],
// k_in[i], idx_in slice i) and holds it until gnt[i] is seen high. gnt[i]
// is a one-cycle registered pulse in the cycle after the command was
// applied. While gnt[i] is high the requester is masked, so it may drop
// req or present a fresh command without risk of a double apply.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 pr,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      j_in,
  input  logic [NREQ-1:0]      k_in,
  input  logic [NREQ*IDXW-1:0] idx_in,
  output logic [NREQ-1:0]      gnt,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     Qbar,
  output logic                 busy,
  output logic                 err
`ifdef JK_TOGGLE_CNT_EN
  ,
  output logic [15:0]          tgl_cnt
`endif
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW:0] BANK_BITS = (IDXW+1)'(WIDTH);
  localparam logic [PTRW-1:0] LAST_REQ = PTRW'(NREQ - 1);

  // Round-robin pointer: search for the next winner starts here.
  logic [PTRW-1:0]  ptr;
  logic [PTRW-1:0]  ptr_next;

  logic [NREQ-1:0]  elig;
  logic             win_found;
  logic [PTRW-1:0]  win_idx;
  logic [NREQ-1:0]  win_onehot;
  logic [IDXW-1:0]  win_b;
  logic             win_j;
  logic             win_k;
  logic             win_in_range;
  logic             win_toggle;
  logic [WIDTH-1:0] next_q;
  int               cand;
  logic [PTRW-1:0]  cand_p;

  // A requester granted last cycle sits out one cycle so a slow req drop
  // cannot cause its command to be applied twice.
  assign elig = req & ~gnt;
  assign busy = |elig;

  // Qbar is purely derived, so it can never disagree with Q.
  assign Qbar = ~Q;

  // Circular priority search from ptr upward, wrapping at NREQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_p    = '0;
    for (int s = 0; s < NREQ; s++) begin
      cand = int'(ptr) + s;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_p = PTRW'(cand);
      if (!win_found && elig[cand_p]) begin
        win_found = 1'b1;
        win_idx   = cand_p;
      end
    end
  end

  // Select the winner's payload and derive its one-hot grant and next pointer.
  always_comb begin
    win_b = '0;
    win_j = 1'b0;
    win_k = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PTRW'(i)) begin
        win_b = idx_in[i*IDXW +: IDXW];
        win_j = j_in[i];
        win_k = k_in[i];
      end
    end
    win_onehot   = NREQ'(1) << win_idx;
    ptr_next     = (win_idx == LAST_REQ) ? '0 : (win_idx + PTRW'(1));
    win_in_range = ({1'b0, win_b} < BANK_BITS);
    win_toggle   = win_found & win_in_range & win_j & win_k;
  end

  // Next bank value: only the addressed bit may change, per JK truth table.
  always_comb begin
    next_q = Q;
    for (int i = 0; i < WIDTH; i++) begin
      if (win_found && win_in_range && (win_b == IDXW'(i))) begin
        case ({win_j, win_k})
          2'b01:   next_q[i] = 1'b0;
          2'b10:   next_q[i] = 1'b1;
          2'b11:   next_q[i] = ~Q[i];
          default: next_q[i] = Q[i];
        endcase
      end
    end
  end

  // Bank, grant, error pulse and pointer; clr beats pr beats arbitration.
  always_ff @(posedge clk) begin
    if (clr) begin
      Q   <= '0;
      gnt <= '0;
      err <= 1'b0;
      ptr <= '0;
    end else if (pr) begin
      Q   <= '1;
      gnt <= '0;
      err <= 1'b0;
    end else if (win_found) begin
      Q   <= next_q;
      gnt <= win_onehot;
      err <= ~win_in_range;
      ptr <= ptr_next;
    end else begin
      gnt <= '0;
      err <= 1'b0;
    end
  end

`ifdef JK_TOGGLE_CNT_EN
  // Saturating count of applied toggles; preset does not touch it.
  always_ff @(posedge clk) begin
    if (clr) begin
      tgl_cnt <= '0;
    end else if (!pr && win_toggle && (tgl_cnt != 16'hFFFF)) begin
      tgl_cnt <= tgl_cnt + 16'd1;
    end
  end
`endif

endmodule
